// File: rtl/cpu_memory.sv
// Stack-CPU memory stage (3a->4a): branch resolution, data-memory load/store over req/ack,
// and registered stack writeback commands. Stalls upstream while a memory access is outstanding.
module cpu_memory (
  input  logic        clk,
  input  logic        rst,
  input  logic        alu__cond_3a,
  input  logic [31:0] alu__out_3a,
  input  logic [1:0]  c__branch_3a,
  input  logic [2:0]  c__to_push_3a,
  input  logic [47:0] instruction_3a,
  input  logic [31:0] pc_3a,
  input  logic [34:0] r0_3a,
  input  logic [34:0] r1_3a,
  input  logic [10:0] st__to_pop_3a,
  input  logic        dmem__ack,
  input  logic [31:0] dmem__rdata,
  output logic        stall_3a,
  output logic        kill_4a,
  output logic [31:0] branch_pc_4a,
  output logic        st__push_4a,
  output logic [34:0] st__push_data_4a,
  output logic [10:0] st__to_pop_4a,
  output logic        dmem__req,
  output logic        dmem__we,
  output logic [31:0] dmem__addr,
  output logic [31:0] dmem__wdata
);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t      state, state_nxt;
  logic        is_load, is_store, is_mem;
  logic        taken;
  logic        push_vld;
  logic [34:0] push_val;
  logic        wb_en, start, done;
  logic        unused_instr;

  assign is_load  = (instruction_3a[41:40] == 2'b01);
  assign is_store = (instruction_3a[41:40] == 2'b10);
  assign is_mem   = is_load || is_store;
  assign unused_instr = ^{instruction_3a[47:42], instruction_3a[39:32]};

  always_comb begin
    taken = 1'b0;
    case (c__branch_3a)
      2'b01:   taken = 1'b1;
      2'b10:   taken = alu__cond_3a;
      2'b11:   taken = !alu__cond_3a;
      default: taken = 1'b0;
    endcase
  end

  // Load data is only a legal push source when this instruction is the load itself.
  always_comb begin
    push_vld = 1'b0;
    push_val = '0;
    case (c__to_push_3a)
      3'b001: begin push_vld = 1'b1; push_val = {3'b000, alu__out_3a}; end
      3'b010: begin push_vld = is_load; push_val = {3'b000, dmem__rdata}; end
      3'b011: begin push_vld = 1'b1; push_val = r0_3a; end
      3'b100: begin push_vld = 1'b1; push_val = r1_3a; end
      3'b101: begin push_vld = 1'b1; push_val = {3'b000, pc_3a + 32'd6}; end
      default: begin push_vld = 1'b0; push_val = '0; end
    endcase
  end

  always_comb begin
    state_nxt = state;
    stall_3a  = 1'b0;
    wb_en     = 1'b0;
    start     = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (!kill_4a) begin
          if (is_mem) begin
            stall_3a  = 1'b1;
            start     = 1'b1;
            state_nxt = WAIT;
          end else begin
            wb_en = 1'b1;
          end
        end
      end
      WAIT: begin
        stall_3a = !dmem__ack;
        if (dmem__ack) begin
          wb_en     = 1'b1;
          done      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      kill_4a          <= 1'b0;
      branch_pc_4a     <= '0;
      st__push_4a      <= 1'b0;
      st__push_data_4a <= '0;
      st__to_pop_4a    <= '0;
      dmem__req        <= 1'b0;
      dmem__we         <= 1'b0;
      dmem__addr       <= '0;
      dmem__wdata      <= '0;
    end else begin
      state         <= state_nxt;
      st__push_4a   <= 1'b0;
      st__to_pop_4a <= '0;
      kill_4a       <= 1'b0;
      if (wb_en) begin
        st__push_4a   <= push_vld;
        st__to_pop_4a <= st__to_pop_3a;
        kill_4a       <= taken;
        if (push_vld) st__push_data_4a <= push_val;
        if (taken)    branch_pc_4a     <= instruction_3a[31:0];
      end
      // Request fields are captured once and held untouched for the whole WAIT.
      if (start) begin
        dmem__req   <= 1'b1;
        dmem__we    <= is_store;
        dmem__addr  <= is_store ? r0_3a[31:0] : alu__out_3a;
        dmem__wdata <= r1_3a[31:0];
      end else if (done) begin
        dmem__req <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cpu_memory.sv
// Table-driven + scoreboard bench for cpu_memory.
module tb_cpu_memory;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu__cond_3a;
  logic [31:0] alu__out_3a;
  logic [1:0]  c__branch_3a;
  logic [2:0]  c__to_push_3a;
  logic [47:0] instruction_3a;
  logic [31:0] pc_3a;
  logic [34:0] r0_3a, r1_3a;
  logic [10:0] st__to_pop_3a;
  logic        dmem__ack;
  logic [31:0] dmem__rdata;
  logic        stall_3a, kill_4a, st__push_4a;
  logic [31:0] branch_pc_4a;
  logic [34:0] st__push_data_4a;
  logic [10:0] st__to_pop_4a;
  logic        dmem__req, dmem__we;
  logic [31:0] dmem__addr, dmem__wdata;

  int n_checks = 0;
  int n_fail   = 0;

  cpu_memory dut (
    .clk(clk), .rst(rst),
    .alu__cond_3a(alu__cond_3a), .alu__out_3a(alu__out_3a),
    .c__branch_3a(c__branch_3a), .c__to_push_3a(c__to_push_3a),
    .instruction_3a(instruction_3a), .pc_3a(pc_3a),
    .r0_3a(r0_3a), .r1_3a(r1_3a), .st__to_pop_3a(st__to_pop_3a),
    .dmem__ack(dmem__ack), .dmem__rdata(dmem__rdata),
    .stall_3a(stall_3a), .kill_4a(kill_4a), .branch_pc_4a(branch_pc_4a),
    .st__push_4a(st__push_4a), .st__push_data_4a(st__push_data_4a),
    .st__to_pop_4a(st__to_pop_4a),
    .dmem__req(dmem__req), .dmem__we(dmem__we),
    .dmem__addr(dmem__addr), .dmem__wdata(dmem__wdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  mop;
    logic [1:0]  br;
    logic        cond;
    logic [2:0]  push;
    logic [31:0] alu;
    logic [31:0] pc;
    logic [34:0] r0;
    logic [34:0] r1;
    logic [10:0] pop;
    logic [31:0] tgt;
    logic        e_stall;
    logic        e_push;
    logic [34:0] e_data;
    logic [10:0] e_pop;
    logic        e_kill;
    logic [31:0] e_bpc;
  } vec_t;

  typedef struct {
    logic        push;
    logic [34:0] data;
    logic [10:0] pop;
    logic        kill;
    logic [31:0] bpc;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  function automatic vec_t mk(
      input logic [1:0] mop, input logic [1:0] br, input logic cond, input logic [2:0] push,
      input logic [31:0] alu, input logic [31:0] pc, input logic [34:0] r0, input logic [34:0] r1,
      input logic [10:0] pop, input logic [31:0] tgt, input logic e_stall, input logic e_push,
      input logic [34:0] e_data, input logic [10:0] e_pop, input logic e_kill, input logic [31:0] e_bpc);
    vec_t v;
    v.mop = mop; v.br = br; v.cond = cond; v.push = push; v.alu = alu; v.pc = pc;
    v.r0 = r0; v.r1 = r1; v.pop = pop; v.tgt = tgt; v.e_stall = e_stall; v.e_push = e_push;
    v.e_data = e_data; v.e_pop = e_pop; v.e_kill = e_kill; v.e_bpc = e_bpc;
    return v;
  endfunction

  task automatic nop_inputs();
    alu__cond_3a = 0; alu__out_3a = 0; c__branch_3a = 0; c__to_push_3a = 0;
    instruction_3a = '0; pc_3a = 0; r0_3a = 0; r1_3a = 0; st__to_pop_3a = 0;
    dmem__ack = 0; dmem__rdata = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_wb(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 1, 0);
      return;
    end
    e = sb.pop_front();
    chk({tag, "_push"}, st__push_4a, e.push);
    chk({tag, "_pop"}, st__to_pop_4a, e.pop);
    chk({tag, "_kill"}, kill_4a, e.kill);
    chk({tag, "_req"}, dmem__req, 0);
    if (e.push) chk({tag, "_data"}, st__push_data_4a, e.data);
    if (e.kill) chk({tag, "_bpc"}, branch_pc_4a, e.bpc);
  endtask

  initial begin
    exp_t e;
    nop_inputs();
    rst = 1;
    tick(); tick();

    chk("rst_push", st__push_4a, 0);
    chk("rst_data", st__push_data_4a, 0);
    chk("rst_pop", st__to_pop_4a, 0);
    chk("rst_kill", kill_4a, 0);
    chk("rst_bpc", branch_pc_4a, 0);
    chk("rst_req", dmem__req, 0);
    chk("rst_we", dmem__we, 0);
    chk("rst_addr", dmem__addr, 0);
    chk("rst_wdata", dmem__wdata, 0);
    rst = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("idle_push", st__push_4a, 0);
      chk("idle_kill", kill_4a, 0);
      chk("idle_req", dmem__req, 0);
      chk("idle_stall", stall_3a, 0);
    end

    // mop br cond push alu pc r0 r1 pop tgt | stall push data pop kill bpc
    vecs.push_back(mk(0, 0, 0, 3'b001, 32'h1234, 32'h1000, 0, 0, 2, 0, 0, 1, 35'h0_0000_1234, 2, 0, 0));
    vecs.push_back(mk(0, 0, 0, 3'b011, 0, 32'h1000, 35'h5_0000_00AA, 0, 0, 0, 0, 1, 35'h5_0000_00AA, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 3'b100, 0, 32'h1000, 0, 35'h7_FFFF_FFFF, 11'h7FF, 0, 0, 1, 35'h7_FFFF_FFFF, 11'h7FF, 0, 0));
    vecs.push_back(mk(0, 0, 0, 3'b101, 0, 32'hFFFF_FFFC, 0, 0, 1, 0, 0, 1, 35'h0_0000_0002, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 3'b010, 32'h9, 32'h1000, 0, 0, 3, 0, 0, 0, 0, 3, 0, 0));
    vecs.push_back(mk(0, 0, 0, 3'b110, 32'h9, 32'h1000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(3, 0, 0, 3'b111, 32'h9, 32'h1000, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0));
    vecs.push_back(mk(0, 2'b10, 1, 3'b001, 32'h77, 32'h1000, 0, 0, 0, 32'h40, 0, 1, 35'h77, 0, 1, 32'h40));
    vecs.push_back(mk(0, 0, 0, 3'b001, 32'h99, 32'h1000, 0, 0, 5, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 2'b10, 0, 3'b000, 0, 32'h1000, 0, 0, 0, 32'h50, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 2'b11, 0, 3'b000, 0, 32'h1000, 0, 0, 0, 32'h80, 0, 0, 0, 0, 1, 32'h80));
    vecs.push_back(mk(0, 2'b01, 0, 3'b000, 0, 32'h1000, 0, 0, 4, 32'h123, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 2'b01, 0, 3'b000, 0, 32'h1000, 0, 0, 0, 32'hCAFE, 0, 0, 0, 0, 1, 32'hCAFE));
    vecs.push_back(mk(1, 0, 0, 3'b010, 32'h500, 32'h1000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 2'b11, 1, 3'b101, 0, 32'h10, 0, 0, 0, 32'h90, 0, 1, 35'h16, 0, 0, 0));

    foreach (vecs[i]) begin
      instruction_3a = '0;
      instruction_3a[41:40] = vecs[i].mop;
      instruction_3a[31:0]  = vecs[i].tgt;
      c__branch_3a = vecs[i].br; alu__cond_3a = vecs[i].cond; c__to_push_3a = vecs[i].push;
      alu__out_3a = vecs[i].alu; pc_3a = vecs[i].pc; r0_3a = vecs[i].r0; r1_3a = vecs[i].r1;
      st__to_pop_3a = vecs[i].pop;
      #1;
      chk($sformatf("vec%0d_stall", i), stall_3a, vecs[i].e_stall);
      e.push = vecs[i].e_push; e.data = vecs[i].e_data; e.pop = vecs[i].e_pop;
      e.kill = vecs[i].e_kill; e.bpc = vecs[i].e_bpc;
      sb.push_back(e);
      tick();
      check_wb($sformatf("vec%0d", i));
    end
    nop_inputs();
    tick();

    // Load with branch-always: ack after three cycles of req.
    instruction_3a[41:40] = 2'b01; instruction_3a[31:0] = 32'h300;
    c__to_push_3a = 3'b010; c__branch_3a = 2'b01; alu__out_3a = 32'h2000; st__to_pop_3a = 1;
    #1;
    chk("ld_stall_n", stall_3a, 1);
    tick();
    chk("ld_req", dmem__req, 1);
    chk("ld_we", dmem__we, 0);
    chk("ld_addr", dmem__addr, 32'h2000);
    chk("ld_push_early", st__push_4a, 0);
    chk("ld_stall_n1", stall_3a, 1);
    tick();
    chk("ld_req2", dmem__req, 1);
    chk("ld_stall_n2", stall_3a, 1);
    dmem__rdata = 32'h1111_1111;
    tick();
    chk("ld_req3", dmem__req, 1);
    chk("ld_addr_hold", dmem__addr, 32'h2000);
    dmem__ack = 1; dmem__rdata = 32'hDEAD_BEEF;
    #1;
    chk("ld_stall_ack", stall_3a, 0);
    tick();
    dmem__ack = 0;
    chk("ld_push", st__push_4a, 1);
    chk("ld_data", st__push_data_4a, 35'h0_DEAD_BEEF);
    chk("ld_pop", st__to_pop_4a, 1);
    chk("ld_kill", kill_4a, 1);
    chk("ld_bpc", branch_pc_4a, 32'h300);
    chk("ld_req_low", dmem__req, 0);
    #1;
    chk("ld_drop_nostall", stall_3a, 0);
    nop_inputs();
    tick();
    chk("ld_after_push", st__push_4a, 0);
    chk("ld_after_kill", kill_4a, 0);
    chk("ld_after_req", dmem__req, 0);

    // Store, ack on the first request cycle.
    instruction_3a[41:40] = 2'b10; r0_3a = 35'h100; r1_3a = 35'h55;
    #1;
    chk("st_stall_n", stall_3a, 1);
    tick();
    chk("st_req", dmem__req, 1);
    chk("st_we", dmem__we, 1);
    chk("st_addr", dmem__addr, 32'h100);
    chk("st_wdata", dmem__wdata, 32'h55);
    dmem__ack = 1;
    #1;
    chk("st_stall_n1", stall_3a, 0);
    tick();
    nop_inputs();
    chk("st_push", st__push_4a, 0);
    chk("st_kill", kill_4a, 0);
    chk("st_req_low", dmem__req, 0);

    // Reset while waiting on memory, then a stale ack.
    tick();
    instruction_3a[41:40] = 2'b01; c__to_push_3a = 3'b010; alu__out_3a = 32'h44;
    tick();
    chk("rw_req", dmem__req, 1);
    rst = 1;
    nop_inputs();
    tick();
    rst = 0;
    chk("rw_req_low", dmem__req, 0);
    dmem__ack = 1; dmem__rdata = 32'h5A5A_5A5A; c__to_push_3a = 3'b010;
    #1;
    chk("rw_stall", stall_3a, 0);
    tick();
    chk("rw_push", st__push_4a, 0);
    chk("rw_req2", dmem__req, 0);
    chk("rw_kill", kill_4a, 0);
    nop_inputs();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cpu_memory.md
# cpu_memory

Stage 3a→4a of the stack CPU pipeline, directly downstream of execute. Resolves branches from the registered ALU condition, performs data-memory loads and stores over a req/ack handshake (stalling upstream while outstanding), and emits the registered stack-writeback commands (push/pop) and the `kill_4a` squash that execute and earlier stages consume.

## Interface
Parameters: none.

Ports (name, direction, width, meaning):
- `clk` in 1: core clock; all state on rising edge.
- `rst` in 1: reset; synchronous, active-high.
- `alu__cond_3a` in 1: registered ALU condition.
- `alu__out_3a` in 32: registered ALU result; load address.
- `c__branch_3a` in 2: 00 none, 01 always, 10 if cond, 11 if !cond.
- `c__to_push_3a` in 3: 000 none, 001 ALU, 010 load data, 011 r0, 100 r1, 101 link (pc+6).
- `instruction_3a` in 48: [41:40] mem op (00 none, 01 load, 10 store, 11 reserved=none); [31:0] branch target.
- `pc_3a` in 32: instruction PC.
- `r0_3a`, `r1_3a` in 35: saved stack tops, [34:32] tag, [31:0] value.
- `st__to_pop_3a` in 11: pop count.
- `dmem__ack` in 1: memory done (read data valid for loads).
- `dmem__rdata` in 32: load data.
- `stall_3a` out 1: combinational; upstream holds 3a registers when high.
- `kill_4a` out 1: squash wrong-path stages 1a–3a.
- `branch_pc_4a` out 32: redirect target, valid when `kill_4a`.
- `st__push_4a` out 1: push strobe.
- `st__push_data_4a` out 35: value to push.
- `st__to_pop_4a` out 11: pop count, applied with the push (pop first).
- `dmem__req`, `dmem__we` out 1; `dmem__addr`, `dmem__wdata` out 32.

## Operation
- State: IDLE, WAIT.
- Drop rule: when `kill_4a`=1, the 3a instruction that cycle is wrong-path: no push, pop, memory or branch effect; no stall.
- IDLE, no mem op: register outputs same edge. Push data by `c__to_push_3a`: ALU→{3'b000,alu__out_3a}; r0/r1→full 35 bits; link→{3'b000,pc_3a+32'd6} (mod 2^32); 010 without a load, or 110/111 → no push. `st__push_4a`=1 iff a valid source is selected.
- IDLE, load/store: `stall_3a`=1; latch addr (load: `alu__out_3a`; store: `r0_3a[31:0]`), wdata `r1_3a[31:0]`, we; →WAIT; `dmem__req`=1 from next cycle.
- WAIT: hold req/addr/we/wdata stable. `stall_3a`=!`dmem__ack`. On ack: register writeback (load data→{3'b000,`dmem__rdata`}), evaluate branch, →IDLE; req low the next cycle.
- Branch taken (01, 10&cond, 11&!cond): `kill_4a`=1, `branch_pc_4a`=`instruction_3a[31:0]`, one cycle.
- Outputs not written in a cycle: strobes/counts 0 (`st__push_4a`, `st__to_pop_4a`, `kill_4a`); data fields hold.

## Timing
- Reset: all outputs 0, state IDLE; `dmem__req` drops next cycle even mid-WAIT (memory must tolerate abandoned requests).
- Non-memory instruction: 1-cycle latency, 3a at edge n → 4a outputs after edge n.
- Memory op entering at cycle n: `stall_3a`=1 at n; req high n+1..m; ack at m≥n+1 → writeback/kill visible after edge m; `stall_3a` low at m. Minimum stall 1 cycle.
- `dmem__ack` outside WAIT ignored.
- Kill and stall never coincide on the same instruction; the dropped instruction is never stalled.

## Test plan
- Reset then idle: all outputs 0, `dmem__req`=0, no strobes for 10 cycles.
- ALU push: alu__out=0x1234, to_push=001, to_pop=2 → next cycle push=1, data=0x000001234, to_pop=2, kill=0.
- Cond branch: c__branch=10, cond=1, target=0x40 → kill=1, branch_pc=0x40 one cycle; following 3a instr with to_push=001 produces no push. Repeat with cond=0 → no kill.
- Load, ack after 3 cycles of req, rdata=0xDEADBEEF: stall 3 cycles, then push data=0x0DEADBEEF, req low next cycle.
- Store r0=0x100, r1=0x55, ack at n+1: req=1 we=1 addr=0x100 wdata=0x55 at n+1, no push, stall only at n.
- Reset asserted during WAIT: state IDLE, req low next cycle, no push when stale ack arrives.
